alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single combinational `alu` datapath between two requesters, e.g. the integer pipeline (port 0) and a secondary unit such as a CSR/address-gen helper (port 1).
- Round-robin arbitration, valid/ready handshake on request and response sides, one-entry registered response buffer per requester.
- Drives the ALU operand/op inputs and captures `alu_out` into the response of the granted requester.
- Rejects unsupported op codes with an error response.

Parameters:
- WIDTH, 32, operand/result width; must match the `alu` instance.
- OPW, 5, ALU op-code width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a / req0_b  in  WIDTH  operands
- req0_op  in  OPW  ALU op code
- rsp0_valid  out  1  result pending for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_result  out  WIDTH  captured ALU result
- rsp0_err  out  1  op code was illegal
- req1_* / rsp1_*  same as port 0, for requester 1
- alu_a / alu_b  out  WIDTH  to ALU operands
- alu_op  out  OPW  to ALU op
- alu_out  in  WIDTH  from ALU result (combinational)

Behaviour:
- Legal ops: ADD 00000, SUB 01000, SLT 00010, SLTU 00011, AND 00111, OR 00110, XOR 00100, SLL 00001, SRL 00101, SRA 01101. Every other code is illegal.
- Slot free: slot_freeN = !rspN_valid || rspN_ready.
- Eligibility: eligN = reqN_valid && slot_freeN.
- Grant, combinational, at most one per cycle:
  - Only one eligible: grant it.
  - Both eligible: grant the requester not named by last_grant.
  - reqN_ready = grantN.
  - Handshake occurs when reqN_valid && reqN_ready.
- Pointer: last_grant updates to the granted index on every handshake, otherwise holds. Reset value 1, so requester 0 wins the first tie.
- ALU drive, combinational:
  - A grant exists: alu_a/alu_b/alu_op = the granted requester's fields.
  - No grant: drive 0/0/ADD.
  - An illegal op is still forwarded to alu_op.
- Capture: on a handshake for N, at the next rising edge:
  - rspN_valid <= 1.
  - Legal op: rspN_result <= alu_out, rspN_err <= 0.
  - Illegal op: rspN_result <= 0, rspN_err <= 1.
  - Latency: exactly 1 cycle from the handshake edge to rspN_valid.
- Response hold:
  - While rspN_valid && !rspN_ready, result and err stay stable.
  - rspN_valid clears on rspN_ready, unless a new handshake for N occurs in the same cycle. In that case valid stays 1 and the new data loads: back-to-back throughput of 1 per cycle per requester.
- Back-pressure:
  - A requester whose slot is full and not draining is never granted; the other may take every cycle.
  - No starvation: with both continuously eligible, grants strictly alternate.
- Request holding: the requester holds fields stable while valid && !ready. The arbiter samples them only at the handshake and does not check stability.
- Reset (rst=1, asynchronous):
  - rsp*_valid=0, rsp*_result=0, rsp*_err=0, last_grant=1.
  - A response pending at reset is discarded.
  - req*_ready evaluates to 0 while rst is high.
  - alu_* outputs are 0/0/ADD while rst is high.
- WIDTH arithmetic is the ALU's. The arbiter does no arithmetic and no width conversion.

Test Plan:
- Reset then single request:
  - Stimulus: rst high 3 cycles, all outputs 0. Release; req0 ADD a=5, b=7, rsp0_ready=1.
  - Response: req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_err=0.
- Contention:
  - Stimulus: both requesters valid every cycle, rsp*_ready=1; req0 SUB 10-3, req1 XOR 0xF0^0xFF.
  - Response: grants 0,1,0,1…; rsp0_result=7 and rsp1_result=0x0F on alternating cycles.
- Back-pressure:
  - Stimulus: rsp0 pending with rsp0_ready=0 for 4 cycles, both requesting.
  - Response: req0_ready=0 throughout; req1 granted all 4 cycles; rsp0_result unchanged.
  - Then rsp0_ready=1: req0 granted in that same cycle, rsp0_valid stays 1 with new data.
- Op coverage:
  - Stimulus: req1 SRA a=0x80000000, b=4; SLT a=0xFFFFFFFF, b=1; SLTU same operands.
  - Response: 0xF8000000, 1, 0 respectively.
  - Plus 1000 random ops per port against a reference model.
- Illegal op:
  - Stimulus: req0_op=5'b11111, a=1, b=1.
  - Response: handshake completes, rsp0_valid=1, rsp0_err=1, rsp0_result=0; next legal op clears err.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously mid-cycle while rsp0_valid=1 and rsp1_valid=1.
  - Response: both clear immediately (before the next edge); after release the first tie goes to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters using
// round-robin arbitration, with a one-entry registered response buffer per port.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [OPW-1:0]   req0_op_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [WIDTH-1:0] rsp0_result_o,
  output logic             rsp0_err_o,
  // requester 1
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [OPW-1:0]   req1_op_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp1_result_o,
  output logic             rsp1_err_o,
  // shared ALU
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OPW-1:0]   alu_op_o,
  input  logic [WIDTH-1:0] alu_out_i
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam logic [OPW-1:0] OpAdd  = OPW'(5'b00000);
  localparam logic [OPW-1:0] OpSub  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OpSlt  = OPW'(5'b00010);
  localparam logic [OPW-1:0] OpSltu = OPW'(5'b00011);
  localparam logic [OPW-1:0] OpAnd  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OpOr   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OpXor  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OpSll  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OpSrl  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OpSra  = OPW'(5'b01101);

  function automatic logic isLegalOp(input logic [OPW-1:0] op);
    case (op)
      OpAdd, OpSub, OpSlt, OpSltu, OpAnd,
      OpOr, OpXor, OpSll, OpSrl, OpSra: isLegalOp = 1'b1;
      default:                          isLegalOp = 1'b0;
    endcase
  endfunction

  port_e            lastGrant_q, lastGrant_d;
  logic             rsp0Valid_q, rsp0Valid_d;
  logic [WIDTH-1:0] rsp0Result_q, rsp0Result_d;
  logic             rsp0Err_q, rsp0Err_d;
  logic             rsp1Valid_q, rsp1Valid_d;
  logic [WIDTH-1:0] rsp1Result_q, rsp1Result_d;
  logic             rsp1Err_q, rsp1Err_d;

  logic             slotFree0, slotFree1;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             aluLegal;
  logic [WIDTH-1:0] capturedResult;

  // Eligibility and round-robin grant; nothing is granted while reset is held.
  always_comb begin
    slotFree0 = !rsp0Valid_q || rsp0_ready_i;
    slotFree1 = !rsp1Valid_q || rsp1_ready_i;
    elig0     = req0_valid_i && slotFree0 && !rst;
    elig1     = req1_valid_i && slotFree1 && !rst;
    grant0    = elig0 && (!elig1 || (lastGrant_q == PORT1));
    grant1    = elig1 && (!elig0 || (lastGrant_q == PORT0));
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Route the granted requester to the ALU; idle drive is 0/0/ADD.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = OpAdd;
    if (grant0) begin
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
      alu_op_o = req0_op_i;
    end else if (grant1) begin
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
      alu_op_o = req1_op_i;
    end
  end

  // Illegal op codes still reach the ALU but capture as result 0 with err set.
  always_comb begin
    aluLegal       = isLegalOp(alu_op_o);
    capturedResult = aluLegal ? alu_out_i : '0;
  end

  // Next state: pointer follows handshakes, buffers load on grant or drain on ready.
  always_comb begin
    lastGrant_d  = lastGrant_q;
    rsp0Valid_d  = rsp0Valid_q;
    rsp0Result_d = rsp0Result_q;
    rsp0Err_d    = rsp0Err_q;
    rsp1Valid_d  = rsp1Valid_q;
    rsp1Result_d = rsp1Result_q;
    rsp1Err_d    = rsp1Err_q;

    if (grant0) begin
      lastGrant_d = PORT0;
    end else if (grant1) begin
      lastGrant_d = PORT1;
    end

    if (grant0) begin
      rsp0Valid_d  = 1'b1;
      rsp0Result_d = capturedResult;
      rsp0Err_d    = !aluLegal;
    end else if (rsp0_ready_i) begin
      rsp0Valid_d  = 1'b0;
    end

    if (grant1) begin
      rsp1Valid_d  = 1'b1;
      rsp1Result_d = capturedResult;
      rsp1Err_d    = !aluLegal;
    end else if (rsp1_ready_i) begin
      rsp1Valid_d  = 1'b0;
    end
  end

  // State registers; reset discards pending responses and favours requester 0 next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant_q  <= PORT1;
      rsp0Valid_q  <= 1'b0;
      rsp0Result_q <= '0;
      rsp0Err_q    <= 1'b0;
      rsp1Valid_q  <= 1'b0;
      rsp1Result_q <= '0;
      rsp1Err_q    <= 1'b0;
    end else begin
      lastGrant_q  <= lastGrant_d;
      rsp0Valid_q  <= rsp0Valid_d;
      rsp0Result_q <= rsp0Result_d;
      rsp0Err_q    <= rsp0Err_d;
      rsp1Valid_q  <= rsp1Valid_d;
      rsp1Result_q <= rsp1Result_d;
      rsp1Err_q    <= rsp1Err_d;
    end
  end

  assign rsp0_valid_o  = rsp0Valid_q;
  assign rsp0_result_o = rsp0Result_q;
  assign rsp0_err_o    = rsp0Err_q;
  assign rsp1_valid_o  = rsp1Valid_q;
  assign rsp1_result_o = rsp1Result_q;
  assign rsp1_err_o    = rsp1Err_q;

endmodule
